hazard_ctrl: RTL

Parametrised pipeline hazard controller for the 5-stage MIPS core, the successor to the single-cycle-decision hazard unit. It resolves jump and branch redirects with a selectable branch-resolution stage, detects load-use hazards with a configurable load latency, and interlocks against a multi-cycle mul/div unit. It supports a global freeze on memory wait and keeps saturating stall and flush performance counters. It sits beside the pipeline registers and drives their stall and flush controls plus the PC source mux.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_sat_counter.sv | 40 ++++
 rtl/hazard_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller:
// FSM state encoding and PC-source mux select constants.
package hazard_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_LU_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   inc_i     - count one this cycle (ignored once all-ones)
//   clr_i     - zero the count; wins over inc_i
//   cnt_o     - current count
module hazard_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, else saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core.
// Resolves jump/branch redirects, inserts load-use and mul/div interlock
// bubbles, freezes the pipeline on memory wait and keeps saturating
// stall/flush performance counters. Control outputs are same-cycle
// combinational decisions; bookkeeping updates on the rising clock edge.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   rs_id, rt_id              - ID-stage source registers
//   rs_read_id, rt_read_id    - ID instruction really reads rs / rt
//   rd_ex, mem_read_ex        - EX destination register, EX is a load
//   jump, branch_taken        - redirect requests
//   md_start, md_use_id       - mul/div issue, ID needs mul/div result
//   mem_wait                  - freeze whole pipeline
//   cnt_clr                   - clear performance counters
//   pc_src, pc_stall          - PC mux select and hold
//   *_stall, *_flush          - pipeline-register controls
//   loaduse, md_busy          - interlock bubble, mul/div in flight
//   stall_cnt, flush_cnt      - saturating performance counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned MD_LAT   = 32,
  parameter int unsigned BR_STAGE = 0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic              rs_read_id,
  input  logic              rt_read_id,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic              mem_read_ex,
  input  logic              jump,
  input  logic              branch_taken,
  input  logic              md_start,
  input  logic              md_use_id,
  input  logic              mem_wait,
  input  logic              cnt_clr,
  output logic [1:0]        pc_src,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_stall,
  output logic              id_ex_flush,
  output logic              ex_mem_stall,
  output logic              ex_mem_flush,
  output logic              mem_wb_stall,
  output logic              mem_wb_flush,
  output logic              loaduse,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned LU_W     = $clog2(MEM_LAT + 1);
  localparam int unsigned MD_W     = $clog2(MD_LAT);
  localparam bit          BR_IN_EX = (BR_STAGE != 0);
  localparam bit          LU_MULTI = (MEM_LAT > 1);

  state_e          state_q, state_d;
  logic [LU_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [MD_W-1:0] md_cnt_q, md_cnt_d;

  logic lu_hit;
  logic md_hit;
  logic br_ex;
  logic br_id;

  // Hazard detection; r0 is never a real dependency.
  always_comb begin
    lu_hit = mem_read_ex && (rd_ex != '0) &&
             ((rs_read_id && (rs_id == rd_ex)) ||
              (rt_read_id && (rt_id == rd_ex)));
    md_busy = (md_cnt_q != '0);
    md_hit  = md_use_id && md_busy;
    br_ex   = BR_IN_EX && branch_taken;
    br_id   = !BR_IN_EX && branch_taken;
  end

  // State, load-use countdown and mul/div busy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lu_cnt_q <= '0;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Next state. The hit cycle itself is the first bubble, so LU_WAIT
  // covers the remaining MEM_LAT-1; it is frozen by mem_wait and
  // abandoned when an EX branch squashes the waiting instruction.
  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!mem_wait && !br_ex && lu_hit && LU_MULTI) begin
          state_d  = ST_LU_WAIT;
          lu_cnt_d = LU_W'(MEM_LAT - 1);
        end
      end
      ST_LU_WAIT: begin
        if (!mem_wait) begin
          if (br_ex) begin
            state_d  = ST_IDLE;
            lu_cnt_d = '0;
          end else begin
            lu_cnt_d = lu_cnt_q - LU_W'(1);
            if (lu_cnt_q == LU_W'(1)) begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        lu_cnt_d = '0;
      end
    endcase
  end

  // Mul/div busy countdown; restarts on every issue, ignores mem_wait.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start) begin
      md_cnt_d = MD_W'(MD_LAT - 1);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MD_W'(1);
    end
  end

  // Per-cycle control decision in priority order.
  always_comb begin
    pc_src       = PC_SEQ;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_stall = 1'b0;
    mem_wb_flush = 1'b0;
    loaduse      = 1'b0;
    if (mem_wait) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_stall = 1'b1;
    end else if (br_ex) begin
      pc_src      = PC_BRANCH;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if ((state_q == ST_LU_WAIT) || lu_hit || md_hit) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
      loaduse     = 1'b1;
    end else if (jump) begin
      pc_src      = PC_JUMP;
      if_id_flush = 1'b1;
    end else if (br_id) begin
      pc_src      = PC_BRANCH;
      if_id_flush = 1'b1;
    end
  end

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (pc_stall),
    .clr_i (cnt_clr),
    .cnt_o (stall_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (if_id_flush | id_ex_flush | ex_mem_flush | mem_wb_flush),
    .clr_i (cnt_clr),
    .cnt_o (flush_cnt)
  );

endmodule
